// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline sequencer for the uPower 5-stage datapath. It decides, each cycle,
// whether the front end advances, whether the IF/ID register is flushed,
// whether a NOP bubble is pushed into ID/EX, and whether the back half of the
// pipeline is frozen while a slow data-memory access completes.
//
// Priority (highest first):
//   1. memory stall / error hold  -> freeze everything
//   2. taken branch in EX         -> flush IF/ID, bubble ID/EX, keep fetching
//   3. load-use hazard            -> hold PC and IF/ID, bubble ID/EX
//   4. normal advance
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   id_rs, id_rt                  source register fields of the ID instruction
//   ex_mem_read, ex_rd            load-in-EX flag and its destination register
//   ex_branch_taken               branch in EX resolved taken
//   mem_req, mem_ready            data-memory access in MEM and its completion
//   pc_write, ifid_write          PC / IF/ID load enables
//   ifid_flush, idex_bubble       IF/ID clear, ID/EX NOP insert
//   pipe_hold                     freeze ID/EX, EX/MEM and MEM/WB
//   mem_err                       sticky memory-timeout flag
//   state_o                       current FSM state for debug
//
// Optional build macro PIPE_HAZARD_STATS_EN adds three 16-bit saturating
// counters: stall_cnt, bubble_cnt, flush_cnt.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic             mem_err,
    output logic [1:0]       state_o
`ifdef PIPE_HAZARD_STATS_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      bubble_cnt,
    output logic [15:0]      flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;

    logic load_use;
    logic mem_stall;
    logic load_use_cyc;

    // A load in EX whose destination feeds either ID source is a hazard;
    // register 0 is hardwired to zero and can never create one.
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (ex_rd == id_rt));

    // The memory stall covers the first cycle of a slow access (still in RUN)
    // as well as every not-ready cycle spent in MEM_WAIT.
    assign mem_stall = ((state_q == RUN) && mem_req && !mem_ready) ||
                       ((state_q == MEM_WAIT) && !mem_ready);

    // Next-state logic for the wait FSM. The counter holds the number of
    // cycles already spent in MEM_WAIT, so reaching TIMEOUT while still not
    // ready means the access has overrun and we park in ERR until reset.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d   = ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ERR: begin
                mem_err_d = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // State, wait counter and sticky error flag; reset abandons any
    // outstanding access and returns straight to RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Pipeline control outputs are combinational from the current state and
    // inputs. The cycle in which MEM_WAIT sees mem_ready is a plain advance:
    // branch and load-use are only re-evaluated once the FSM is back in RUN.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        if (!reset_n) begin
            pipe_hold = 1'b0;
        end else if (state_q == ERR) begin
            pipe_hold = 1'b1;
        end else if (mem_stall) begin
            pipe_hold = 1'b1;
        end else if (state_q == MEM_WAIT) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
        end else if (ex_branch_taken) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            idex_bubble = 1'b1;
        end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
        end
    end

    assign state_o      = reset_n ? state_q : RUN;
    assign mem_err      = mem_err_q;
    assign load_use_cyc = idex_bubble && !ifid_flush;

`ifdef PIPE_HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;

    // Event counters for performance debug; each saturates instead of
    // wrapping so a long run never reports a misleadingly small number.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (pipe_hold && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (load_use_cyc && (bubble_cnt_q != 16'hFFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
            end
            if (ifid_flush && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl. A stimulus process drives one set
// of inputs per cycle, runs the reference model for that cycle and queues the
// expected outputs; a monitor process samples the DUT on the falling edge and
// compares against the head of the queue.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int REG_W   = 5;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble;
    logic             pipe_hold, mem_err;
    logic [1:0]       state_o;

    typedef struct packed {
        logic       pcw;
        logic       ifw;
        logic       fl;
        logic       bub;
        logic       hold;
        logic       err;
        logic [1:0] st;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: which phase the memory port is in (0 idle, 1 waiting,
    // 2 failed), how many cycles it has waited, and the sticky error.
    int mMode   = 0;
    int mWaited = 0;
    bit mErr    = 0;

    pipe_hazard_ctrl #(.REG_W(REG_W), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .pipe_hold       (pipe_hold),
        .mem_err         (mem_err),
        .state_o         (state_o)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // One cycle of the reference model: expected outputs for the inputs now
    // applied, then advance the model to the next cycle.
    task automatic modelCycle(input bit rst, input bit loadUse, input bit br,
                              input bit req, input bit rdy, output exp_t e);
        e = '0;
        if (!rst) begin
            mMode   = 0;
            mWaited = 0;
            mErr    = 0;
            return;
        end
        e.err = mErr;
        e.st  = 2'(mMode);
        if (mMode == 2) begin
            e.hold = 1'b1;
        end else if ((mMode == 0 && req && !rdy) || (mMode == 1 && !rdy)) begin
            e.hold = 1'b1;
        end else if (mMode == 1) begin
            e.pcw = 1'b1;
            e.ifw = 1'b1;
        end else if (br) begin
            e.pcw = 1'b1;
            e.ifw = 1'b1;
            e.fl  = 1'b1;
            e.bub = 1'b1;
        end else if (loadUse) begin
            e.bub = 1'b1;
        end else begin
            e.pcw = 1'b1;
            e.ifw = 1'b1;
        end
        if (mMode == 0) begin
            if (req && !rdy) begin
                mMode   = 1;
                mWaited = 1;
            end
        end else if (mMode == 1) begin
            if (rdy) begin
                mMode   = 0;
                mWaited = 0;
            end else if (mWaited == TIMEOUT) begin
                mMode = 2;
                mErr  = 1;
            end else begin
                mWaited++;
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input logic [4:0] rs,
                                 input logic [4:0] rt, input bit mr,
                                 input logic [4:0] rd, input bit br,
                                 input bit req, input bit rdy);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        reset_n         = rst;
        id_rs           = rs;
        id_rt           = rt;
        ex_mem_read     = mr;
        ex_rd           = rd;
        ex_branch_taken = br;
        mem_req         = req;
        mem_ready       = rdy;
        lu = mr && (rd != 0) && ((rd == rs) || (rd == rt));
        modelCycle(rst, lu, br, req, rdy, e);
        expQ.push_back(e);
    endtask

    // Reset asserted between clock edges must clear outputs at once.
    task automatic asyncResetMidCycle();
        exp_t e;
        @(posedge clk);
        #1;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_state_o", 8'(state_o), 8'h00);
        checkOutput("async_pipe_hold", 8'(pipe_hold), 8'h00);
        checkOutput("async_pc_write", 8'(pc_write), 8'h00);
        checkOutput("async_mem_err", 8'(mem_err), 8'h00);
        modelCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e);
        expQ.push_back(e);
    endtask

    // Monitor: every falling edge with an outstanding expectation, compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("pc_write", 8'(pc_write), 8'(e.pcw));
                checkOutput("ifid_write", 8'(ifid_write), 8'(e.ifw));
                checkOutput("ifid_flush", 8'(ifid_flush), 8'(e.fl));
                checkOutput("idex_bubble", 8'(idex_bubble), 8'(e.bub));
                checkOutput("pipe_hold", 8'(pipe_hold), 8'(e.hold));
                checkOutput("mem_err", 8'(mem_err), 8'(e.err));
                checkOutput("state_o", 8'(state_o), 8'(e.st));
            end
        end
    end

    // Directed scenarios first, then a long randomized run.
    initial begin
        reset_n = 1'b0;
        id_rs = '0; id_rt = '0; ex_rd = '0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
        $display("[TB] start");

        applyStimulus(0, 5'd1, 5'd2, 1, 5'd1, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        applyStimulus(1, 5'd5, 5'd7, 1, 5'd5, 0, 0, 0);
        applyStimulus(1, 5'd3, 5'd7, 1, 5'd5, 0, 0, 0);
        applyStimulus(1, 5'd3, 5'd5, 1, 5'd5, 0, 0, 0);
        applyStimulus(1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0);
        applyStimulus(1, 5'd5, 5'd7, 1, 5'd5, 1, 0, 0);

        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);

        applyStimulus(1, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < TIMEOUT + 4; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        asyncResetMidCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 299) != 0),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        checkOutput("queue_drained", 8'(expQ.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the uPower 5-stage datapath. It generates the PC/IF-ID write enables, the IF/ID flush, the ID/EX bubble and the EX/MEM/WB hold.
- Resolves three conditions: load-use hazards, taken-branch flushes, and multi-cycle data-memory accesses with a ready handshake.
- Sits beside the main control unit, which supplies MemRead/MemWrite/Branch through the pipeline registers. It consumes register fields from the ID and EX stages.

Parameters:
- REG_W, 5, width of register specifier fields.
- TIMEOUT, 16, maximum MEM_WAIT cycles before the error state; range 2..255.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- id_rs  in  REG_W  source reg A of instruction in ID
- id_rt  in  REG_W  source reg B of instruction in ID
- ex_mem_read  in  1  ID/EX MemRead (load in EX)
- ex_rd  in  REG_W  destination reg of instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_req  in  1  EX/MEM MemRead|MemWrite (access in MEM)
- mem_ready  in  1  data memory done this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  zero IF/ID contents
- idex_bubble  out  1  load NOP controls into ID/EX
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB
- mem_err  out  1  sticky memory timeout flag
- state_o  out  2  current FSM state (debug)

Behaviour:
- FSM states: RUN=2'b00, MEM_WAIT=2'b01, ERR=2'b10; 2'b11 is illegal and recovers to RUN.
- reset_n low, asynchronous: state=RUN, wait_cnt=0, mem_err=0.
- While reset_n is low, all outputs are forced: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0, pipe_hold=0, state_o=00.
- Outputs are combinational from the current state and inputs; there is no added latency.
- Memory stall (highest priority), asserted when (state==RUN and mem_req and !mem_ready) or state==MEM_WAIT and !mem_ready:
  - pc_write=0, ifid_write=0, pipe_hold=1, ifid_flush=0, idex_bubble=0.
  - ex_branch_taken and load-use are ignored; they re-evaluate after the release, since all stages are frozen.
- FSM transitions:
  - RUN to MEM_WAIT when mem_req and !mem_ready; wait_cnt is set to 1.
  - MEM_WAIT to RUN on mem_ready. The pipeline advances in that same cycle with no stall outputs; wait_cnt clears.
  - MEM_WAIT with !mem_ready: wait_cnt increments. If wait_cnt==TIMEOUT, go to ERR.
  - ERR: mem_err=1, pipe_hold=1, pc_write=0, ifid_write=0. Held until reset; mem_ready is ignored.
  - A zero-wait access (mem_req with mem_ready both high in RUN) causes no stall and no state change.
- Branch flush (priority 2, in RUN with no memory stall), when ex_branch_taken=1:
  - ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
  - Load-use is suppressed, because the ID instruction is wrong-path.
- Load-use (priority 3), when ex_mem_read and ex_rd!=0 and (ex_rd==id_rs or ex_rd==id_rt):
  - pc_write=0, ifid_write=0, idex_bubble=1 for exactly the one cycle the condition holds.
  - Register 0 never hazards.
- Otherwise: pc_write=1, ifid_write=1, all other outputs 0.
- Reset mid-MEM_WAIT or in ERR returns to RUN immediately (asynchronously); the outstanding access is abandoned.

Optional Feature:
- Macro: PIPE_HAZARD_STATS_EN.
- When defined, adds outputs stall_cnt, bubble_cnt and flush_cnt, each 16 bits:
  - stall_cnt counts cycles with pipe_hold=1.
  - bubble_cnt counts load-use cycles.
  - flush_cnt counts flush cycles.
  - All counters are saturating at 16'hFFFF and cleared by reset_n.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5 -> pc_write=0, ifid_write=0, idex_bubble=1 for one cycle. Repeat with ex_rd=0, id_rs=0 -> no stall.
- Branch and load-use together: ex_branch_taken=1 with a load-use match -> ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles, then high -> pipe_hold=1 for 3 cycles, state 00->01->01->01->00, release in the ready cycle. Zero-wait access (mem_ready=1 immediately) -> no stall.
- Memory stall with a pending branch: mem_req=1, mem_ready=0, ex_branch_taken=1 -> ifid_flush=0 during the stall; flush asserts in the cycle after the release.
- Timeout: TIMEOUT=16, mem_ready held 0 -> state_o=10 and mem_err=1 after 16 wait cycles. A later mem_ready=1 has no effect; reset_n pulse -> RUN, mem_err=0.
- Asynchronous reset in MEM_WAIT between clock edges -> all outputs 0 and state_o=00 immediately, without waiting for a clock edge.
